// File: rtl/card_shoe_pkg.sv
// Shared types and constants for the finite-deck card shoe.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package card_pkg;

    typedef logic [3:0] card_t;

    localparam card_t CARD_NONE = 4'd0;
    localparam card_t CARD_ACE  = 4'd1;
    localparam card_t CARD_KING = 4'd13;

    localparam int DECK_SIZE = 52;

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

endpackage

// File: rtl/card_shoe_if.sv
// Request/response bundle between the baccarat datapath and the card shoe.
// Latency: none (wiring only).
// Backpressure: none; the datapath must wait for card_valid before the next req.
interface card_shoe_if;
    import card_pkg::*;

    logic       req;
    logic       shuffle;
    card_t      new_card;
    logic       card_valid;
    logic       busy;
    logic       empty;
    logic [5:0] cards_left;

    // Datapath side: issues requests and refills, observes the dealt card.
    modport master (
        output req,
        output shuffle,
        input  new_card,
        input  card_valid,
        input  busy,
        input  empty,
        input  cards_left
    );

    // Shoe side: accepts requests and reports the dealt card and shoe status.
    modport slave (
        input  req,
        input  shuffle,
        output new_card,
        output card_valid,
        output busy,
        output empty,
        output cards_left
    );

endinterface

// File: rtl/card_shoe_rank_ptr_counter.sv
// Free-running rank pointer cycling CARD_ACE..LAST, advancing every clock.
// Latency: new value every cycle; resets to CARD_ACE asynchronously.
// Backpressure: none; it never stalls.
module rank_ptr_counter
    import card_pkg::*;
#(
    parameter card_t LAST = CARD_KING
) (
    input  logic  CLOCK_50,
    input  logic  resetb,
    output card_t rank_ptr
);

    // Advance one rank per cycle, wrapping the last rank back to the Ace.
    always_ff @(posedge CLOCK_50 or negedge resetb) begin
        if (!resetb) begin
            rank_ptr <= CARD_ACE;
        end else if (rank_ptr == LAST) begin
            rank_ptr <= CARD_ACE;
        end else begin
            rank_ptr <= rank_ptr + 4'd1;
        end
    end

endmodule

// File: rtl/card_shoe.sv
// 52-card shoe dealing ranks without replacement; randomness from a free-running rank pointer.
// Latency: 2..14 edges from sampled req to card_valid (1 + skipped exhausted ranks + 1).
// Backpressure: req ignored while busy or empty; shuffle only honoured in IDLE, and wins over req.
module card_shoe
    import card_pkg::*;
#(
    parameter int COPIES = 4,
    parameter int NRANKS = 13
) (
    input  logic         CLOCK_50,
    input  logic         resetb,
    card_shoe_if.slave   bus
);

    localparam int DECK = COPIES * NRANKS;

    state_t     state_q, state_d;
    card_t      probe_q, probe_d;
    card_t      rank_ptr;
    logic [2:0] count_q [1:NRANKS];
    logic [2:0] probe_cnt;
    logic [5:0] cards_left_q;
    card_t      new_card_q;
    logic       card_valid_q;
    logic       deal;
    logic       refill;
    logic       empty;

    rank_ptr_counter #(
        .LAST (card_t'(NRANKS))
    ) u_rank_ptr (
        .CLOCK_50 (CLOCK_50),
        .resetb   (resetb),
        .rank_ptr (rank_ptr)
    );

    assign empty = (cards_left_q == 6'd0);

    // Look up how many copies of the currently probed rank are still in the shoe.
    always_comb begin
        probe_cnt = 3'd0;
        for (int r = 1; r <= NRANKS; r++) begin
            if (probe_q == card_t'(r)) begin
                probe_cnt = count_q[r];
            end
        end
    end

    // FSM state and probe registers.
    always_ff @(posedge CLOCK_50 or negedge resetb) begin
        if (!resetb) begin
            state_q <= IDLE;
            probe_q <= CARD_NONE;
        end else begin
            state_q <= state_d;
            probe_q <= probe_d;
        end
    end

    // Next-state logic: start a search from the pointer, then walk ranks until one has copies left.
    always_comb begin
        state_d = state_q;
        probe_d = probe_q;
        deal    = 1'b0;
        refill  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.shuffle) begin
                    refill = 1'b1;
                end else if (bus.req && !empty) begin
                    probe_d = rank_ptr;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (probe_cnt != 3'd0) begin
                    deal    = 1'b1;
                    state_d = IDLE;
                end else if (probe_q == card_t'(NRANKS)) begin
                    probe_d = CARD_ACE;
                end else begin
                    probe_d = probe_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-rank remaining copies: refill on shuffle, take one on a deal.
    always_ff @(posedge CLOCK_50 or negedge resetb) begin
        if (!resetb) begin
            for (int r = 1; r <= NRANKS; r++) begin
                count_q[r] <= 3'(COPIES);
            end
        end else begin
            for (int r = 1; r <= NRANKS; r++) begin
                if (refill) begin
                    count_q[r] <= 3'(COPIES);
                end else if (deal && probe_q == card_t'(r)) begin
                    count_q[r] <= count_q[r] - 3'd1;
                end
            end
        end
    end

    // Output registers: the dealt card persists between deals and survives a shuffle.
    always_ff @(posedge CLOCK_50 or negedge resetb) begin
        if (!resetb) begin
            cards_left_q <= 6'(DECK);
            new_card_q   <= CARD_NONE;
            card_valid_q <= 1'b0;
        end else begin
            card_valid_q <= deal;
            if (refill) begin
                cards_left_q <= 6'(DECK);
            end else if (deal) begin
                cards_left_q <= cards_left_q - 6'd1;
                new_card_q   <= probe_q;
            end
        end
    end

    assign bus.new_card   = new_card_q;
    assign bus.card_valid = card_valid_q;
    assign bus.busy       = (state_q == SEARCH);
    assign bus.empty      = empty;
    assign bus.cards_left = cards_left_q;

endmodule

// File: tb/tb_card_shoe.sv
// Directed self-checking bench for card_shoe.
// Latency: tracks the rank pointer with its own 1..13 counter to time requests.
// Backpressure: waits for each card_valid (bounded) before issuing the next request.
module tb_card_shoe;
    import card_pkg::*;

    logic clk;
    logic resetb;
    int   n_checks;
    int   n_fail;
    int   tb_ptr;
    int   mcnt [1:13];
    int   last_card;

    card_shoe_if bus ();

    card_shoe dut (
        .CLOCK_50 (clk),
        .resetb   (resetb),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent model of the free-running rank pointer.
    always @(posedge clk or negedge resetb) begin
        if (!resetb) tb_ptr <= 1;
        else         tb_ptr <= (tb_ptr == 13) ? 1 : tb_ptr + 1;
    end

    // Expected card for a search starting at 'target', and how many ranks get skipped.
    task automatic model_pick(input int target, output int card, output int skips);
        int r;
        r = target;
        skips = 0;
        card = 0;
        for (int i = 0; i < 13; i++) begin
            if (card == 0) begin
                if (mcnt[r] > 0) card = r;
                else begin
                    skips++;
                    r = (r == 13) ? 1 : r + 1;
                end
            end
        end
    endtask

    task automatic model_refill();
        for (int r = 1; r <= 13; r++) mcnt[r] = 4;
    endtask

    // Wait for the pointer to reach 'target', pulse req (optionally with shuffle), observe up to 20 edges.
    task automatic do_req(input int target, input bit with_shuffle,
                          output int card, output int edges, output int busy_cnt, output bit got);
        int guard;
        guard = 0;
        while (tb_ptr != target && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bus.req = 1'b1;
        bus.shuffle = with_shuffle;
        got = 1'b0;
        edges = 0;
        busy_cnt = 0;
        card = 0;
        while (!got && edges < 20) begin
            @(negedge clk);
            bus.req = 1'b0;
            bus.shuffle = 1'b0;
            edges++;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.card_valid === 1'b1) begin
                got = 1'b1;
                card = int'(bus.new_card);
            end
        end
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        bus.req = 1'b0;
        bus.shuffle = 1'b0;
        model_refill();
        last_card = 0;
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        n_checks++;
        if (bus.new_card !== 4'd0) begin
            n_fail++; $display("FAIL reset_new_card: got %0d expected 0", bus.new_card);
        end
        n_checks++;
        if (bus.card_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_card_valid: got %b expected 0", bus.card_valid);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
        end
        n_checks++;
        if (bus.empty !== 1'b0) begin
            n_fail++; $display("FAIL reset_empty: got %b expected 0", bus.empty);
        end
        n_checks++;
        if (bus.cards_left !== 6'(DECK_SIZE)) begin
            n_fail++; $display("FAIL reset_cards_left: got %0d expected %0d", bus.cards_left, DECK_SIZE);
        end
    endtask

    task automatic test_first_deal();
        int card, edges, busy_cnt;
        bit got;
        do_req(1, 1'b0, card, edges, busy_cnt, got);
        mcnt[1]--;
        last_card = 1;
        n_checks++;
        if (!got || edges !== 2) begin
            n_fail++; $display("FAIL first_latency: got %0d edges (valid=%b) expected 2", edges, got);
        end
        n_checks++;
        if (card !== 1) begin
            n_fail++; $display("FAIL first_card: got %0d expected 1", card);
        end
        n_checks++;
        if (bus.cards_left !== 6'd51) begin
            n_fail++; $display("FAIL first_cards_left: got %0d expected 51", bus.cards_left);
        end
        n_checks++;
        if (busy_cnt !== 1) begin
            n_fail++; $display("FAIL first_busy_cycles: got %0d expected 1", busy_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (bus.card_valid !== 1'b0) begin
            n_fail++; $display("FAIL first_strobe_width: got %b expected 0", bus.card_valid);
        end
    endtask

    task automatic test_skip();
        int card, edges, busy_cnt;
        bit got;
        for (int i = 0; i < 3; i++) begin
            do_req(1, 1'b0, card, edges, busy_cnt, got);
            mcnt[1]--;
            n_checks++;
            if (!got || card !== 1 || edges !== 2) begin
                n_fail++; $display("FAIL ace_deal_%0d: got card %0d after %0d edges expected 1 after 2", i, card, edges);
            end
        end
        do_req(1, 1'b0, card, edges, busy_cnt, got);
        mcnt[2]--;
        last_card = 2;
        n_checks++;
        if (!got || card !== 2) begin
            n_fail++; $display("FAIL skip_card: got %0d (valid=%b) expected 2", card, got);
        end
        n_checks++;
        if (edges !== 3) begin
            n_fail++; $display("FAIL skip_latency: got %0d edges expected 3", edges);
        end
        n_checks++;
        if (bus.cards_left !== 6'd47) begin
            n_fail++; $display("FAIL skip_cards_left: got %0d expected 47", bus.cards_left);
        end
        n_checks++;
        if (dut.count_q[1] !== 3'd0) begin
            n_fail++; $display("FAIL skip_ace_count: got %0d expected 0", dut.count_q[1]);
        end
    endtask

    task automatic test_shuffle_with_req();
        int card, edges, busy_cnt, exp_card, skips;
        bit got;
        for (int i = 0; i < 17; i++) begin
            do_req(((i * 5) % 13) + 1, 1'b0, card, edges, busy_cnt, got);
            model_pick(((i * 5) % 13) + 1, exp_card, skips);
            mcnt[exp_card]--;
            last_card = exp_card;
            n_checks++;
            if (!got || card !== exp_card || edges !== skips + 2) begin
                n_fail++; $display("FAIL partial_deal_%0d: got card %0d after %0d edges expected %0d after %0d",
                                   i, card, edges, exp_card, skips + 2);
            end
        end
        n_checks++;
        if (bus.cards_left !== 6'd30) begin
            n_fail++; $display("FAIL partial_cards_left: got %0d expected 30", bus.cards_left);
        end
        do_req(tb_ptr, 1'b1, card, edges, busy_cnt, got);
        model_refill();
        n_checks++;
        if (got || busy_cnt !== 0) begin
            n_fail++; $display("FAIL shuffle_req_dropped: got valid=%b busy_cycles=%0d expected 0 and 0", got, busy_cnt);
        end
        n_checks++;
        if (bus.cards_left !== 6'd52) begin
            n_fail++; $display("FAIL shuffle_cards_left: got %0d expected 52", bus.cards_left);
        end
        n_checks++;
        if (bus.new_card !== 4'(last_card)) begin
            n_fail++; $display("FAIL shuffle_new_card_kept: got %0d expected %0d", bus.new_card, last_card);
        end
    endtask

    task automatic test_drain();
        int card, edges, busy_cnt, exp_card, skips, target, tally_bad;
        int tally [1:13];
        bit got;
        for (int r = 1; r <= 13; r++) tally[r] = 0;
        for (int i = 0; i < 52; i++) begin
            target = $urandom_range(13, 1);
            repeat ($urandom_range(3, 0)) @(negedge clk);
            do_req(target, 1'b0, card, edges, busy_cnt, got);
            model_pick(target, exp_card, skips);
            mcnt[exp_card]--;
            last_card = exp_card;
            if (card >= 1 && card <= 13) tally[card]++;
            n_checks++;
            if (!got || card !== exp_card || edges !== skips + 2) begin
                n_fail++; $display("FAIL drain_deal_%0d: got card %0d after %0d edges expected %0d after %0d",
                                   i, card, edges, exp_card, skips + 2);
            end
        end
        tally_bad = 0;
        for (int r = 1; r <= 13; r++) if (tally[r] != 4) tally_bad++;
        n_checks++;
        if (tally_bad !== 0) begin
            n_fail++; $display("FAIL drain_rank_tally: got %0d ranks not dealt 4 times expected 0", tally_bad);
        end
        n_checks++;
        if (bus.cards_left !== 6'd0) begin
            n_fail++; $display("FAIL drain_cards_left: got %0d expected 0", bus.cards_left);
        end
        n_checks++;
        if (bus.empty !== 1'b1) begin
            n_fail++; $display("FAIL drain_empty: got %b expected 1", bus.empty);
        end
        do_req(tb_ptr, 1'b0, card, edges, busy_cnt, got);
        n_checks++;
        if (got || busy_cnt !== 0) begin
            n_fail++; $display("FAIL empty_req_ignored: got valid=%b busy_cycles=%0d expected 0 and 0", got, busy_cnt);
        end
    endtask

    task automatic test_reset_mid_search();
        int card, edges, busy_cnt;
        bit got, saw_valid;
        bus.shuffle = 1'b1;
        @(negedge clk);
        bus.shuffle = 1'b0;
        model_refill();
        for (int r = 1; r <= 12; r++) begin
            for (int k = 0; k < 4; k++) begin
                do_req(r, 1'b0, card, edges, busy_cnt, got);
                mcnt[r]--;
                n_checks++;
                if (!got || card !== r) begin
                    n_fail++; $display("FAIL exhaust_rank_%0d_%0d: got %0d (valid=%b) expected %0d", r, k, card, got, r);
                end
            end
        end
        while (tb_ptr != 1) @(negedge clk);
        bus.req = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.req = 1'b0;
            if (bus.card_valid === 1'b1) saw_valid = 1'b1;
        end
        n_checks++;
        if (bus.busy !== 1'b1 || saw_valid) begin
            n_fail++; $display("FAIL long_search_busy: got busy=%b valid_seen=%b expected 1 and 0", bus.busy, saw_valid);
        end
        resetb = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.card_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_busy_valid: got busy=%b valid=%b expected 0 and 0", bus.busy, bus.card_valid);
        end
        n_checks++;
        if (bus.cards_left !== 6'd52) begin
            n_fail++; $display("FAIL abort_cards_left: got %0d expected 52", bus.cards_left);
        end
        n_checks++;
        if (bus.new_card !== 4'd0) begin
            n_fail++; $display("FAIL abort_new_card: got %0d expected 0", bus.new_card);
        end
        repeat (2) @(negedge clk);
        resetb = 1'b1;
        saw_valid = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (bus.card_valid === 1'b1 || bus.busy === 1'b1) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid) begin
            n_fail++; $display("FAIL abort_no_late_strobe: activity seen after reset expected none");
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        bus.req = 1'b0;
        bus.shuffle = 1'b0;
        resetb = 1'b1;
        #2;
        test_reset();
        test_first_deal();
        test_skip();
        test_shuffle_with_req();
        test_drain();
        test_reset_mid_search();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete within bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/card_shoe.md
# card_shoe

Finite-deck card source for the baccarat datapath. It replaces the infinite free-running dealer with a 52-card shoe: four copies of each rank, Ace..King, dealt without replacement. It sits directly upstream of the datapath's card registers. On each request it returns one card in the 1..13 encoding already used by the score and 7-segment logic. A fast free-running rank pointer clocked by CLOCK_50 supplies the randomness, so the value dealt depends on when the slow step key is pressed.

## Interface
Parameters:
- COPIES, default 4: copies of each rank in a full shoe.
- NRANKS, default 13: ranks per suit; rank codes are 1..NRANKS.

Ports:
- CLOCK_50  in  1  the single clock; every register is clocked by it.
- resetb  in  1  asynchronous, active-low reset.
- req  in  1  level-sampled deal request; a 1-cycle pulse is expected.
- shuffle  in  1  refills the shoe.
- new_card  out  4  last card dealt; 0 means no card yet.
- card_valid  out  1  1-cycle strobe; new_card is fresh.
- busy  out  1  high while a search is in progress.
- empty  out  1  high when cards_left == 0.
- cards_left  out  6  number of cards remaining, 0..52.

## Operation
- rank_ptr: 4-bit, free-running; sequence 1,2,...,13,1,... advancing every cycle in every state.
- count[r], r = 1..13: 3-bit remaining copies of each rank; full value COPIES.
- FSM states:
  - IDLE: busy = 0.
  - SEARCH: busy = 1; holds a 4-bit probe register.
- In IDLE:
  - shuffle = 1: all count[r] <= 4 and cards_left <= 52; stay in IDLE. shuffle has priority over a simultaneous req, which is dropped.
  - else req = 1 and empty = 0: probe <= rank_ptr, go to SEARCH.
  - req = 1 and empty = 1: ignored; no strobe, no state change.
- In SEARCH, each cycle:
  - count[probe] > 0: count[probe] decrements, cards_left decrements, new_card <= probe, card_valid = 1 for one cycle, go to IDLE.
  - otherwise probe <= next(probe), with 13 wrapping to 1.
  - req and shuffle are ignored in SEARCH; nothing is queued.
- Because empty = 0 on entry, a non-zero rank always exists, so a search ends within 13 probes.
- new_card holds its value between deals and is never cleared by shuffle.
- Arithmetic: cards_left is unsigned 6-bit. It never goes below 0, because entering SEARCH requires empty = 0, and never goes above 52.

## Timing
- Reset values (asynchronous, immediate):
  - FSM = IDLE; rank_ptr = 1; all count[r] = 4; cards_left = 52.
  - new_card = 0; card_valid = 0; busy = 0; empty = 0.
- Latency: req is sampled at edge N. card_valid is high for the cycle following edge N+1+m, where m is the number of exhausted ranks skipped (0..12). Minimum latency is 2 edges, maximum 14.
- busy rises after edge N and falls with the same edge that raises card_valid.
- empty, cards_left and new_card all update on the edge that raises card_valid.
- Reset asserted in SEARCH aborts the deal: no strobe, and the shoe returns to full.
- The datapath must not sample new_card until card_valid has been seen. The slow step period must exceed 14 CLOCK_50 cycles.

## Structure
- Package card_pkg holds:
  - typedef card_t (logic [3:0]);
  - CARD_NONE = 0, CARD_ACE = 1, CARD_KING = 13;
  - DECK_SIZE = 52;
  - the enum state_t {IDLE, SEARCH}.
- Sub-module rank_ptr_counter is the free-running 1..13 wrap counter with asynchronous reset. It is the natural split and can later be reused by the legacy dealer.
- The card_shoe top level holds the count array, the FSM, the probe register and the output registers.

## Test plan
- Reset: release resetb, then check new_card = 0, card_valid = 0, busy = 0, empty = 0, cards_left = 52.
- First deal: req at the first edge after reset, while rank_ptr = 1. Expect card_valid 2 edges later, new_card = 1, cards_left = 51, busy high for exactly 1 cycle.
- Skip: deal four Aces by timing req when rank_ptr = 1, then issue a fifth req with rank_ptr = 1. Expect new_card = 2 after 3 edges, count[1] = 0, cards_left = 47.
- Drain: issue 52 reqs at pseudo-random offsets. Expect every rank dealt exactly 4 times and, after the last deal, cards_left = 0 and empty = 1. A 53rd req gives no card_valid within 20 cycles and busy stays 0.
- Shuffle with req: assert shuffle and req together in IDLE on a partly drained shoe (cards_left = 30). Expect cards_left = 52, no card_valid, new_card unchanged.
- Reset mid-search: exhaust ranks 1..12, req with rank_ptr = 1, then assert resetb = 0 after 5 cycles. Expect immediately busy = 0, no card_valid, cards_left = 52, new_card = 0.
